phy_config_ctrl: RTL and testbench
==================================

Name: phy_config_ctrl

Overview:
- PHY bring-up sequencer that sits directly upstream of mdio_transmit and drives its start/read/phy_addr/reg_addr/write_data inputs.
- Consumes mdio_transmit's done/read_data outputs.
- After reset it soft-resets the PHY, polls for reset completion, writes the BMCR configuration, then waits for autonegotiation and link.
- Once configured, it re-reads BMSR periodically and reports link status to the Ethernet datapath.

Parameters:
- PHY_ADDR, 5'd1, MDIO address of the PHY
- CFG_BMCR, 16'h1140, BMCR value written after soft reset (AN enable, full duplex, 1000M select bits)
- PWRUP_WAIT, 1000, mdc cycles to wait after reset release before the first transaction
- POLL_GAP, 200, idle mdc cycles between consecutive poll reads
- RST_POLL_MAX, 16, max BMCR reads while waiting for bit15 to clear
- AN_POLL_MAX, 4096, max BMSR reads while waiting for autonegotiation complete
- LINK_POLL, 5000, mdc cycles between BMSR reads in the monitor state

Ports:
- mdc  in  1  block clock; same clock as mdio_transmit
- reset_n  in  1  synchronous active-low reset, sampled on the rising edge of mdc
- restart  in  1  one-cycle pulse; re-runs the full sequence from the power-up wait
- mdio_start  out  1  one-cycle request pulse to mdio_transmit
- mdio_read  out  1  1 = read, 0 = write
- mdio_phy_addr  out  5  PHY address
- mdio_reg_addr  out  5  register address
- mdio_wdata  out  16  write data
- mdio_done  in  1  one-cycle completion pulse from mdio_transmit
- mdio_rdata  in  16  read data; valid in the mdio_done cycle
- busy  out  1  sequence in progress, i.e. not in MONITOR or ERROR
- cfg_done  out  1  configuration completed successfully (sticky until reset or restart)
- cfg_error  out  1  poll timeout occurred (sticky until reset or restart)
- link_up  out  1  last sampled BMSR bit2

Behaviour:
- Clock and reset: one clock (mdc); reset is synchronous and active-low on reset_n.
- Reset values:
  - state = PWR_WAIT, all counters = 0
  - mdio_start = 0, mdio_read = 0, mdio_reg_addr = 0, mdio_wdata = 0
  - mdio_phy_addr = PHY_ADDR
  - busy = 1, cfg_done = 0, cfg_error = 0, link_up = 0
- Handshake with mdio_transmit:
  - mdio_start is high for exactly one cycle per transaction.
  - mdio_read, mdio_reg_addr and mdio_wdata are set in the same cycle as mdio_start and held stable until mdio_done is sampled high.
  - mdio_start is never re-asserted while a transaction is outstanding.
  - mdio_done arriving while no transaction is outstanding is ignored.
- State machine (each *_WR and *_RD state issues one transaction on entry, then waits for mdio_done):
  - PWR_WAIT: count PWRUP_WAIT cycles -> RST_WR.
  - RST_WR: write reg 0 = 16'h8000. On done -> RST_GAP.
  - RST_GAP: wait POLL_GAP cycles -> RST_RD.
  - RST_RD: read reg 0. On done:
    - rdata[15] = 0 -> CFG_WR
    - rdata[15] = 1 and the RST read count has reached RST_POLL_MAX -> ERROR
    - otherwise -> RST_GAP
  - CFG_WR: write reg 0 = CFG_BMCR. On done -> AN_GAP.
  - AN_GAP: wait POLL_GAP cycles -> AN_RD.
  - AN_RD: read reg 1. On done:
    - link_up <= rdata[2]
    - rdata[5] = 1 -> MONITOR, with cfg_done <= 1
    - AN read count has reached AN_POLL_MAX -> ERROR
    - otherwise -> AN_GAP
  - MONITOR: wait LINK_POLL cycles, read reg 1, set link_up <= rdata[2], repeat indefinitely.
  - ERROR: cfg_error = 1. No further transactions; hold until restart or reset.
- Poll counters count completed reads; a read returning the success condition on exactly the MAX-th read counts as success.
- Gap and wait counters are sized with $clog2 of the parameter plus 1. Zero-valued gap parameters mean proceed on the next cycle.
- restart in any state:
  - clears cfg_done, cfg_error and link_up; go to PWR_WAIT.
  - If a transaction is outstanding, the block first drains it: it waits for mdio_done, discards the data, then enters PWR_WAIT.
  - restart arriving in the same cycle as mdio_done: the done completes the drain; the result is discarded.
- reset_n low at any point, including mid-transaction, returns all state to reset values on the next edge. mdio_transmit shares reset_n, so no drain is needed.

Decomposition:
- Shared package phy_mdio_pkg holds:
  - register addresses: REG_BMCR = 5'd0, REG_BMSR = 5'd1
  - bit indices: BMCR_RESET = 15, BMSR_AN_DONE = 5, BMSR_LINK = 2
  - the state encoding localparams, so that status/debug logic and the testbench can decode state
- One natural sub-module: mdio_txn_issuer. It owns the start pulse, argument hold and outstanding/drain flag, and presents a req/ack interface to the FSM. The top-level FSM and counters stay in phy_config_ctrl.

Test Plan:
- Nominal bring-up. Behavioural mdio_transmit model (done 64 cycles after start) returns BMCR 0x8000 twice then 0x1140, and BMSR 0x7949 then 0x796D -> transaction sequence:
  - W0=8000
  - R0, R0, R0
  - W0=1140
  - R1, R1
  - then cfg_done=1, link_up=1, busy=0
- Reset timeout: BMCR always reads 0x8000 -> exactly 16 reg-0 reads, then cfg_error=1 and no further mdio_start.
- Link drop in MONITOR: BMSR changes to 0x7969 -> link_up falls within one LINK_POLL period plus one transaction; cfg_done stays 1.
- Handshake integrity: assert that mdio_start is never high while a transaction is outstanding, and that args are stable from start to done; mdio_done is delayed randomly between 1 and 200 cycles.
- Restart mid-transaction during the CFG_WR write -> no new start until done, then PWR_WAIT (1000 cycles), then W0=8000 reissued; flags cleared in the restart cycle.
- reset_n asserted mid-AN_RD for 3 cycles -> all outputs equal reset values on the next edge; sequence restarts from PWR_WAIT.

Source files
------------

// File: rtl/phy_mdio_pkg.sv
// Shared MDIO register map, bit positions and sequencer state encoding for the PHY
// bring-up logic and anything that needs to decode its state.
package phy_mdio_pkg;

    localparam logic [4:0]  REG_BMCR      = 5'd0;
    localparam logic [4:0]  REG_BMSR      = 5'd1;
    localparam int          BMCR_RESET    = 15;
    localparam int          BMSR_AN_DONE  = 5;
    localparam int          BMSR_LINK     = 2;
    localparam logic [15:0] BMCR_SOFT_RST = 16'h8000;

    localparam logic [3:0] ST_PWR_WAIT = 4'd0;
    localparam logic [3:0] ST_RST_WR   = 4'd1;
    localparam logic [3:0] ST_RST_GAP  = 4'd2;
    localparam logic [3:0] ST_RST_RD   = 4'd3;
    localparam logic [3:0] ST_CFG_WR   = 4'd4;
    localparam logic [3:0] ST_AN_GAP   = 4'd5;
    localparam logic [3:0] ST_AN_RD    = 4'd6;
    localparam logic [3:0] ST_MON_WAIT = 4'd7;
    localparam logic [3:0] ST_MON_RD   = 4'd8;
    localparam logic [3:0] ST_ERROR    = 4'd9;
    localparam logic [3:0] ST_DRAIN    = 4'd10;

    typedef enum logic [3:0] {
        S_PWR_WAIT = ST_PWR_WAIT,
        S_RST_WR   = ST_RST_WR,
        S_RST_GAP  = ST_RST_GAP,
        S_RST_RD   = ST_RST_RD,
        S_CFG_WR   = ST_CFG_WR,
        S_AN_GAP   = ST_AN_GAP,
        S_AN_RD    = ST_AN_RD,
        S_MON_WAIT = ST_MON_WAIT,
        S_MON_RD   = ST_MON_RD,
        S_ERROR    = ST_ERROR,
        S_DRAIN    = ST_DRAIN
    } state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // One spare bit so a counter can reach the limit itself without wrapping.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/phy_config_ctrl_if.sv
// Request/completion signals between the bring-up sequencer and mdio_transmit.
interface phy_config_ctrl_if;
    logic        mdio_start;
    logic        mdio_read;
    logic [4:0]  mdio_phy_addr;
    logic [4:0]  mdio_reg_addr;
    logic [15:0] mdio_wdata;
    logic        mdio_done;
    logic [15:0] mdio_rdata;

    modport master (
        output mdio_start, mdio_read, mdio_phy_addr, mdio_reg_addr, mdio_wdata,
        input  mdio_done, mdio_rdata
    );

    modport slave (
        input  mdio_start, mdio_read, mdio_phy_addr, mdio_reg_addr, mdio_wdata,
        output mdio_done, mdio_rdata
    );
endinterface

// File: rtl/mdio_txn_issuer.sv
// Turns a single-cycle request into an mdio_transmit transaction: one start pulse, args held
// until done, and a discard flag so an aborted transaction drains without reporting data.
module mdio_txn_issuer #(
    parameter logic [4:0] PHY_ADDR = 5'd1
) (
    input  logic              mdc,
    input  logic              reset_n,
    input  logic              i_req,
    input  logic              i_read,
    input  logic [4:0]        i_reg_addr,
    input  logic [15:0]       i_wdata,
    input  logic              i_abort,
    output logic              o_pending,
    output logic              o_ack,
    output logic [15:0]       o_rdata,
    phy_config_ctrl_if.master mdio
);

    logic        r_start;
    logic        r_read;
    logic [4:0]  r_reg_addr;
    logic [15:0] r_wdata;
    logic        r_outstanding;
    logic        r_discard;
    logic        w_done;
    logic        w_accept;

    // A done with nothing outstanding is ignored entirely.
    assign w_done    = r_outstanding & mdio.mdio_done;
    assign o_pending = r_outstanding & ~w_done;
    assign w_accept  = i_req & ~o_pending;
    assign o_ack     = w_done & ~r_discard & ~i_abort;
    assign o_rdata   = mdio.mdio_rdata;

    always_ff @(posedge mdc) begin
        if (!reset_n) begin
            r_start       <= 1'b0;
            r_read        <= 1'b0;
            r_reg_addr    <= '0;
            r_wdata       <= '0;
            r_outstanding <= 1'b0;
            r_discard     <= 1'b0;
        end else begin
            r_start <= w_accept;
            if (w_accept) begin
                r_read     <= i_read;
                r_reg_addr <= i_reg_addr;
                r_wdata    <= i_wdata;
            end
            if (w_accept)
                r_outstanding <= 1'b1;
            else if (w_done)
                r_outstanding <= 1'b0;
            if (w_done)
                r_discard <= 1'b0;
            else if (i_abort && r_outstanding)
                r_discard <= 1'b1;
        end
    end

    assign mdio.mdio_start    = r_start;
    assign mdio.mdio_read     = r_read;
    assign mdio.mdio_phy_addr = PHY_ADDR;
    assign mdio.mdio_reg_addr = r_reg_addr;
    assign mdio.mdio_wdata    = r_wdata;

endmodule

// File: rtl/phy_config_ctrl.sv
// PHY bring-up sequencer: soft reset, poll reset clear, write BMCR, wait for autoneg,
// then poll BMSR forever and report link. Transactions go out through mdio_txn_issuer.
module phy_config_ctrl
    import phy_mdio_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR     = 5'd1,
    parameter logic [15:0] CFG_BMCR     = 16'h1140,
    parameter int unsigned PWRUP_WAIT   = 1000,
    parameter int unsigned POLL_GAP     = 200,
    parameter int unsigned RST_POLL_MAX = 16,
    parameter int unsigned AN_POLL_MAX  = 4096,
    parameter int unsigned LINK_POLL    = 5000
) (
    input  logic              mdc,
    input  logic              reset_n,
    input  logic              restart,
    phy_config_ctrl_if.master mdio,
    output logic              busy,
    output logic              cfg_done,
    output logic              cfg_error,
    output logic              link_up
);

    localparam int unsigned CNT_W  = cnt_width(max_u(max_u(PWRUP_WAIT, POLL_GAP), LINK_POLL));
    localparam int unsigned POLL_W = cnt_width(max_u(RST_POLL_MAX, AN_POLL_MAX));

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [POLL_W-1:0]   r_poll, w_poll_nxt;
    logic                r_cfg_done, w_cfg_done_nxt;
    logic                r_cfg_error, w_cfg_error_nxt;
    logic                r_link_up, w_link_up_nxt;
    logic                w_req, w_req_read;
    logic [4:0]          w_req_reg;
    logic [15:0]         w_req_wdata;
    logic                w_pending, w_ack;
    logic [15:0]         w_rdata;

    // A zero or one cycle limit lets the wait state leave on its first cycle.
    function automatic logic elapsed(input logic [CNT_W-1:0] cnt, input int unsigned lim);
        return (cnt + CNT_W'(1)) >= CNT_W'(lim);
    endfunction

    mdio_txn_issuer #(.PHY_ADDR(PHY_ADDR)) u_issuer (
        .mdc        (mdc),
        .reset_n    (reset_n),
        .i_req      (w_req),
        .i_read     (w_req_read),
        .i_reg_addr (w_req_reg),
        .i_wdata    (w_req_wdata),
        .i_abort    (restart),
        .o_pending  (w_pending),
        .o_ack      (w_ack),
        .o_rdata    (w_rdata),
        .mdio       (mdio)
    );

    always_ff @(posedge mdc) begin
        if (!reset_n) begin
            r_state     <= S_PWR_WAIT;
            r_cnt       <= '0;
            r_poll      <= '0;
            r_cfg_done  <= 1'b0;
            r_cfg_error <= 1'b0;
            r_link_up   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_poll      <= w_poll_nxt;
            r_cfg_done  <= w_cfg_done_nxt;
            r_cfg_error <= w_cfg_error_nxt;
            r_link_up   <= w_link_up_nxt;
        end
    end

    // Requests are issued on the transition into a *_WR/*_RD state.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt + CNT_W'(1);
        w_poll_nxt      = r_poll;
        w_cfg_done_nxt  = r_cfg_done;
        w_cfg_error_nxt = r_cfg_error;
        w_link_up_nxt   = r_link_up;
        w_req           = 1'b0;
        w_req_read      = 1'b0;
        w_req_reg       = REG_BMCR;
        w_req_wdata     = '0;
        if (restart) begin
            w_state_nxt     = w_pending ? S_DRAIN : S_PWR_WAIT;
            w_cnt_nxt       = '0;
            w_poll_nxt      = '0;
            w_cfg_done_nxt  = 1'b0;
            w_cfg_error_nxt = 1'b0;
            w_link_up_nxt   = 1'b0;
        end else begin
            case (r_state)
                S_PWR_WAIT: if (elapsed(r_cnt, PWRUP_WAIT)) begin
                    w_state_nxt = S_RST_WR;
                    w_req       = 1'b1;
                    w_req_wdata = BMCR_SOFT_RST;
                end
                S_RST_WR: if (w_ack) w_state_nxt = S_RST_GAP;
                S_RST_GAP: if (elapsed(r_cnt, POLL_GAP)) begin
                    w_state_nxt = S_RST_RD;
                    w_req       = 1'b1;
                    w_req_read  = 1'b1;
                end
                S_RST_RD: if (w_ack) begin
                    w_poll_nxt = r_poll + POLL_W'(1);
                    if (!w_rdata[BMCR_RESET]) begin
                        w_state_nxt = S_CFG_WR;
                        w_poll_nxt  = '0;
                        w_req       = 1'b1;
                        w_req_wdata = CFG_BMCR;
                    end else if (w_poll_nxt >= POLL_W'(RST_POLL_MAX)) begin
                        w_state_nxt     = S_ERROR;
                        w_cfg_error_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_RST_GAP;
                    end
                end
                S_CFG_WR: if (w_ack) w_state_nxt = S_AN_GAP;
                S_AN_GAP: if (elapsed(r_cnt, POLL_GAP)) begin
                    w_state_nxt = S_AN_RD;
                    w_req       = 1'b1;
                    w_req_read  = 1'b1;
                    w_req_reg   = REG_BMSR;
                end
                S_AN_RD: if (w_ack) begin
                    w_poll_nxt    = r_poll + POLL_W'(1);
                    w_link_up_nxt = w_rdata[BMSR_LINK];
                    if (w_rdata[BMSR_AN_DONE]) begin
                        w_state_nxt    = S_MON_WAIT;
                        w_cfg_done_nxt = 1'b1;
                    end else if (w_poll_nxt >= POLL_W'(AN_POLL_MAX)) begin
                        w_state_nxt     = S_ERROR;
                        w_cfg_error_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_AN_GAP;
                    end
                end
                S_MON_WAIT: if (elapsed(r_cnt, LINK_POLL)) begin
                    w_state_nxt = S_MON_RD;
                    w_req       = 1'b1;
                    w_req_read  = 1'b1;
                    w_req_reg   = REG_BMSR;
                end
                S_MON_RD: if (w_ack) begin
                    w_link_up_nxt = w_rdata[BMSR_LINK];
                    w_state_nxt   = S_MON_WAIT;
                end
                S_DRAIN: if (!w_pending) w_state_nxt = S_PWR_WAIT;
                S_ERROR: ;
                default: w_state_nxt = S_PWR_WAIT;
            endcase
            if (w_state_nxt != r_state)
                w_cnt_nxt = '0;
        end
    end

    assign busy      = !(r_state inside {S_MON_WAIT, S_MON_RD, S_ERROR});
    assign cfg_done  = r_cfg_done;
    assign cfg_error = r_cfg_error;
    assign link_up   = r_link_up;

endmodule

// File: tb/tb_phy_config_ctrl.sv
// Bench for phy_config_ctrl: behavioural mdio_transmit model plus a transaction scoreboard.
module tb_phy_config_ctrl;
    import phy_mdio_pkg::*;

    logic mdc = 1'b0;
    logic reset_n = 1'b0;
    logic restart = 1'b0;
    logic busy, cfg_done, cfg_error, link_up;

    phy_config_ctrl_if u_if ();

    phy_config_ctrl u_dut (
        .mdc       (mdc),
        .reset_n   (reset_n),
        .restart   (restart),
        .mdio      (u_if),
        .busy      (busy),
        .cfg_done  (cfg_done),
        .cfg_error (cfg_error),
        .link_up   (link_up)
    );

    always #5 mdc = ~mdc;

    int n_cmp = 0;
    int n_bad = 0;
    int n_start = 0;
    int n_rd0 = 0;
    logic [21:0] exp_q[$];          // {read, reg_addr, wdata}

    logic [15:0] r0_q[$];
    logic [15:0] r1_q[$];
    logic [15:0] r0_def = 16'h0000;
    logic [15:0] r1_def = 16'h796D;
    bit          rand_dly = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // mdio_transmit stand-in: done a fixed 64 or random 1..200 cycles after start
    int          m_cnt = 0;
    bit          m_busy = 1'b0;
    logic [15:0] m_data = '0;
    always @(negedge mdc) begin
        u_if.mdio_done = 1'b0;
        if (!reset_n) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            if (m_cnt <= 1) begin
                u_if.mdio_done  = 1'b1;
                u_if.mdio_rdata = m_data;
                m_busy = 1'b0;
            end else begin
                m_cnt--;
            end
        end else if (u_if.mdio_start === 1'b1) begin
            m_busy = 1'b1;
            m_cnt  = rand_dly ? int'($urandom_range(200, 1)) : 64;
            if (!u_if.mdio_read)
                m_data = 16'h0000;
            else if (u_if.mdio_reg_addr == REG_BMCR)
                m_data = (r0_q.size() > 0) ? r0_q.pop_front() : r0_def;
            else
                m_data = (r1_q.size() > 0) ? r1_q.pop_front() : r1_def;
        end
    end

    // Scoreboard monitor: every start is popped against the expected queue
    bit          mon_out = 1'b0;
    bit          arg_bad = 1'b0;
    logic [21:0] mon_args = '0;
    logic [21:0] e;
    always @(negedge mdc) begin
        #1;
        if (!reset_n) begin
            mon_out = 1'b0;
        end else if (u_if.mdio_start === 1'b1) begin
            n_start++;
            if (u_if.mdio_read && u_if.mdio_reg_addr == REG_BMCR) n_rd0++;
            check("start_while_outstanding", mon_out, 1'b0);
            check("txn_phy_addr", u_if.mdio_phy_addr, 5'd1);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL txn_unexpected: got read=%0b reg=%0d wdata=%h expected no transaction",
                         u_if.mdio_read, u_if.mdio_reg_addr, u_if.mdio_wdata);
            end else begin
                e = exp_q.pop_front();
                check("txn_read", u_if.mdio_read, e[21]);
                check("txn_reg", u_if.mdio_reg_addr, e[20:16]);
                if (!e[21]) check("txn_wdata", u_if.mdio_wdata, e[15:0]);
            end
            mon_out  = 1'b1;
            arg_bad  = 1'b0;
            mon_args = {u_if.mdio_read, u_if.mdio_reg_addr, u_if.mdio_wdata};
        end else if (mon_out) begin
            if ({u_if.mdio_read, u_if.mdio_reg_addr, u_if.mdio_wdata} !== mon_args) arg_bad = 1'b1;
            if (u_if.mdio_done) begin
                check("args_stable", arg_bad, 1'b0);
                mon_out = 1'b0;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge mdc);
            #2;
        end
    endtask

    task automatic push(input logic rd, input logic [4:0] rg, input logic [15:0] wd);
        exp_q.push_back({rd, rg, wd});
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return cfg_done;
            1:       return cfg_error;
            2:       return link_up;
            default: return busy;
        endcase
    endfunction

    task automatic wait_sig(input string name, input int sel, input logic val, input int budget);
        int k = 0;
        while (sig(sel) !== val && k < budget) begin
            cyc(1);
            k++;
        end
        check(name, sig(sel), val);
    endtask

    task automatic wait_starts(input string name, input int target, input int budget);
        int k = 0;
        while (n_start < target && k < budget) begin
            cyc(1);
            k++;
        end
        check(name, n_start, target);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, busy, 1'b1);
        check({tag, "_cfg_done"}, cfg_done, 1'b0);
        check({tag, "_cfg_error"}, cfg_error, 1'b0);
        check({tag, "_link_up"}, link_up, 1'b0);
        check({tag, "_start"}, u_if.mdio_start, 1'b0);
        check({tag, "_read"}, u_if.mdio_read, 1'b0);
        check({tag, "_reg"}, u_if.mdio_reg_addr, 5'd0);
        check({tag, "_wdata"}, u_if.mdio_wdata, 16'h0000);
        check({tag, "_phy"}, u_if.mdio_phy_addr, 5'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 100000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, s1, s2, rd0_base;

        cyc(2);
        check_reset_vals("reset");

        // Nominal bring-up
        r0_q = '{16'h8000, 16'h8000, 16'h1140};
        r1_q = '{16'h7949, 16'h796D};
        push(1'b0, REG_BMCR, 16'h8000);
        push(1'b1, REG_BMCR, 16'h0);
        push(1'b1, REG_BMCR, 16'h0);
        push(1'b1, REG_BMCR, 16'h0);
        push(1'b0, REG_BMCR, 16'h1140);
        push(1'b1, REG_BMSR, 16'h0);
        push(1'b1, REG_BMSR, 16'h0);
        reset_n = 1'b1;
        wait_sig("nom_cfg_done", 0, 1'b1, 4000);
        check("nom_link_up", link_up, 1'b1);
        check("nom_busy", busy, 1'b0);
        check("nom_cfg_error", cfg_error, 1'b0);
        check("nom_all_txns_seen", exp_q.size(), 0);
        check("nom_bmcr_reads", n_rd0, 3);

        // Link drop seen by the monitor poll
        r1_def = 16'h7969;
        push(1'b1, REG_BMSR, 16'h0);
        wait_sig("drop_link_low", 2, 1'b0, 5100);
        check("drop_cfg_done_held", cfg_done, 1'b1);
        check("drop_busy", busy, 1'b0);

        // Restart from MONITOR clears flags, then full sequence after power-up wait
        s0 = n_start;
        r0_def = 16'h0000;
        r1_def = 16'h7949;
        push(1'b0, REG_BMCR, 16'h8000);
        push(1'b1, REG_BMCR, 16'h0);
        push(1'b0, REG_BMCR, 16'h1140);
        restart = 1'b1;
        cyc(1);
        restart = 1'b0;
        check("mrst_cfg_done_clr", cfg_done, 1'b0);
        check("mrst_busy", busy, 1'b1);
        cyc(900);
        check("mrst_pwr_wait", n_start, s0);
        wait_starts("mrst_reissue", s0 + 1, 200);
        wait_starts("mrst_cfg_wr", s0 + 3, 1000);

        // Restart in the middle of the CFG_WR write: drain, then power-up wait again
        cyc(10);
        restart = 1'b1;
        cyc(1);
        restart = 1'b0;
        check("crst_busy", busy, 1'b1);
        check("crst_cfg_error", cfg_error, 1'b0);
        s1 = n_start;
        push(1'b0, REG_BMCR, 16'h8000);
        push(1'b1, REG_BMCR, 16'h0);
        push(1'b0, REG_BMCR, 16'h1140);
        push(1'b1, REG_BMSR, 16'h0);
        cyc(40);
        check("crst_no_start_in_drain", n_start, s1);
        cyc(900);
        check("crst_pwr_wait", n_start, s1);
        wait_starts("crst_reissue", s1 + 1, 300);
        wait_starts("crst_an_rd", s1 + 4, 1500);

        // reset_n mid AN_RD, then BMCR never clears under random done delays
        cyc(10);
        reset_n = 1'b0;
        cyc(1);
        check_reset_vals("midrst");
        cyc(2);
        exp_q.delete();
        r0_def   = 16'h8000;
        rand_dly = 1'b1;
        push(1'b0, REG_BMCR, 16'h8000);
        for (int i = 0; i < 16; i++) push(1'b1, REG_BMCR, 16'h0);
        s2       = n_start;
        rd0_base = n_rd0;
        reset_n  = 1'b1;
        cyc(900);
        check("midrst_pwr_wait", n_start, s2);
        wait_starts("midrst_reissue", s2 + 1, 200);
        wait_sig("to_cfg_error", 1, 1'b1, 9000);
        check("to_bmcr_reads", n_rd0 - rd0_base, 16);
        check("to_cfg_done", cfg_done, 1'b0);
        check("to_busy", busy, 1'b0);
        check("to_all_txns_seen", exp_q.size(), 0);
        cyc(2000);
        check("to_no_more_starts", n_start, s2 + 17);
        check("to_error_sticky", cfg_error, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
